gj_axis_uart_tx_gen2: RTL and testbench

Parametrised AXI-Stream-to-UART serializer, successor to the fixed 8-bit transmitter in the gjAxisUart family. It supports a run-time character length, five parity modes, one or two stop bits, per-byte and per-frame idle gaps, and line-break generation. It has an optional compile-time input FIFO. It sits between a byte-stream producer and the pad driver; bit timing comes from an external one-tick-per-bit `clk_en`.

---
 rtl/gj_uart_pkg.sv | 28 ++
 rtl/gj_uart_sync_fifo.sv | 42 ++++
 rtl/gj_axis_uart_tx_gen2.sv | 238 +++++++++++++++++++++++
 tb/tb_gj_axis_uart_tx_gen2.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gj_uart_pkg.sv
// Shared types and constants for the gj_axis_uart_tx_gen2 serializer.
// Parity codes, FSM state encoding, character and break limits.
package gj_uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam int MIN_BITS  = 5;
  localparam int MAB_TICKS = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP,
    S_BREAK
  } state_e;

  function automatic logic [2:0] norm_parity(input logic [2:0] p);
    return (p > PAR_SPACE) ? PAR_NONE : p;
  endfunction

endpackage

// File: rtl/gj_uart_sync_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of 2.
// Read data is the head entry, valid whenever empty is low.
module gj_uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gj_axis_uart_tx_gen2.sv
// AXI-Stream to UART serializer: 5..DATA_W bits, parity, 1/2 stop, gaps, break.
// Define GJ_UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the FSM.
module gj_axis_uart_tx_gen2
  import gj_uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [3:0]        cfg_bits,
  input  logic [2:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              cfg_gap_en,
  input  logic [GAP_W-1:0]  byte_gap,
  input  logic [GAP_W-1:0]  frame_gap,
  input  logic [GAP_W-1:0]  brk_len,
  input  logic              brk_tvalid,
  output logic              brk_tready,
  input  logic              powerDown_tvalid,
  output logic              powerDown_tready,
  input  logic              tx_tvalid,
  output logic              tx_tready,
  input  logic [DATA_W-1:0] tx_tdata,
  input  logic              tx_tlast,
  output logic              tx,
  output logic              txEn
);

  state_e             state;
  logic [DATA_W-1:0]  sh;
  logic [3:0]         bits_l;
  logic [3:0]         bit_cnt;
  logic               par_en_l;
  logic               pbit_l;
  logic               stop2_l;
  logic               stop_left;
  logic               gap_en_l;
  logic               last_l;
  logic               mab;
  logic [GAP_W-1:0]   bgap_l;
  logic [GAP_W-1:0]   fgap_l;
  logic [GAP_W-1:0]   cnt;

  logic               src_valid;
  logic [DATA_W-1:0]  src_data;
  logic               src_last;
  logic               q_empty;
  logic               idle_now;
  logic               win;
  logic               brk_go;
  logic               chr_go;
  logic [3:0]         bits_c;
  logic [2:0]         par_c;
  logic [DATA_W-1:0]  masked;
  logic               pbit_c;
  logic [GAP_W-1:0]   sel_gap;
  logic               gap_go;
  logic               unused_ok;

  assign unused_ok = &{1'b0, powerDown_tvalid, 1'(FIFO_DEPTH)};

  assign sel_gap = last_l ? fgap_l : bgap_l;
  assign gap_go  = gap_en_l && (sel_gap != '0);

  // IDLE is re-entered on the final edge of a sequence, so a new
  // character or break can start on that same edge with no idle bit.
  always_comb begin
    idle_now = 1'b0;
    unique case (state)
      S_IDLE:  idle_now = 1'b1;
      S_STOP:  idle_now = !stop_left && !gap_go;
      S_GAP:   idle_now = (cnt == '0);
      S_BREAK: idle_now = mab && (cnt == '0);
      default: idle_now = 1'b0;
    endcase
  end

  assign win        = clk_en && idle_now;
  assign brk_tready = win && !rst;
  assign brk_go     = win && brk_tvalid && !rst;
  assign chr_go     = win && src_valid && !brk_tvalid && !rst;

  assign powerDown_tready =
    (state == S_IDLE) && !brk_tvalid && q_empty && !rst;

`ifdef GJ_UART_TX_FIFO_EN
  logic              f_full;
  logic              f_empty;
  logic [DATA_W:0]   f_rdata;

  gj_uart_sync_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_tvalid && tx_tready),
    .wdata({tx_tlast, tx_tdata}),
    .pop  (chr_go),
    .rdata(f_rdata),
    .full (f_full),
    .empty(f_empty)
  );

  assign tx_tready = !f_full && !rst;
  assign src_valid = !f_empty;
  assign src_data  = f_rdata[DATA_W-1:0];
  assign src_last  = f_rdata[DATA_W];
  assign q_empty   = f_empty;
`else
  assign tx_tready = win && !brk_tvalid && !rst;
  assign src_valid = tx_tvalid;
  assign src_data  = tx_tdata;
  assign src_last  = tx_tlast;
  assign q_empty   = 1'b1;
`endif

  always_comb begin
    bits_c = cfg_bits;
    if (cfg_bits < 4'(MIN_BITS))    bits_c = 4'(MIN_BITS);
    else if (cfg_bits > 4'(DATA_W)) bits_c = 4'(DATA_W);
  end

  always_comb begin
    masked = '0;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(bits_c)) masked[i] = src_data[i];
  end

  assign par_c = norm_parity(cfg_parity);

  always_comb begin
    pbit_c = 1'b0;
    unique case (1'b1)
      (par_c == PAR_EVEN): pbit_c = ^masked;
      (par_c == PAR_ODD):  pbit_c = ~^masked;
      (par_c == PAR_MARK): pbit_c = 1'b1;
      default:             pbit_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      txEn      <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      stop_left <= 1'b0;
      mab       <= 1'b0;
    end else if (clk_en) begin
      unique case (state)
        S_START: begin
          state   <= S_DATA;
          tx      <= sh[0];
          sh      <= sh >> 1;
          bit_cnt <= 4'd1;
        end
        S_DATA: begin
          if (bit_cnt == bits_l) begin
            if (par_en_l) begin
              state <= S_PARITY;
              tx    <= pbit_l;
            end else begin
              state     <= S_STOP;
              tx        <= 1'b1;
              stop_left <= stop2_l;
            end
          end else begin
            tx      <= sh[0];
            sh      <= sh >> 1;
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_PARITY: begin
          state     <= S_STOP;
          tx        <= 1'b1;
          stop_left <= stop2_l;
        end
        S_STOP: begin
          if (stop_left) begin
            stop_left <= 1'b0;
          end else begin
            if (last_l) txEn <= 1'b0;
            if (gap_go) begin
              state <= S_GAP;
              cnt   <= sel_gap - 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        S_BREAK: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!mab) begin
            mab <= 1'b1;
            cnt <= GAP_W'(MAB_TICKS - 1);
            tx  <= 1'b1;
          end else begin
            state <= S_IDLE;
            txEn  <= 1'b0;
          end
        end
        default: ;
      endcase

      if (brk_go) begin
        state <= S_BREAK;
        tx    <= 1'b0;
        txEn  <= 1'b1;
        mab   <= 1'b0;
        cnt   <= (brk_len == '0) ? '0 : brk_len - 1'b1;
      end else if (chr_go) begin
        state    <= S_START;
        tx       <= 1'b0;
        txEn     <= 1'b1;
        sh       <= src_data;
        last_l   <= src_last;
        bits_l   <= bits_c;
        par_en_l <= (par_c != PAR_NONE);
        pbit_l   <= pbit_c;
        stop2_l  <= cfg_stop2;
        gap_en_l <= cfg_gap_en;
        bgap_l   <= byte_gap;
        fgap_l   <= frame_gap;
      end
    end
  end

endmodule

// File: tb/tb_gj_axis_uart_tx_gen2.sv
// Directed bench for gj_axis_uart_tx_gen2: vector table plus gap/break/FIFO/reset sequences.
// Line samples are taken once per bit tick, just before each clk_en edge.
module tb_gj_axis_uart_tx_gen2;

  localparam int DW = 9;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b0;
  logic [1:0]    en_cnt = 2'd0;
  logic [3:0]    cfg_bits = 4'd8;
  logic [2:0]    cfg_parity = 3'd0;
  logic          cfg_stop2 = 1'b0;
  logic          cfg_gap_en = 1'b0;
  logic [GW-1:0] byte_gap = '0;
  logic [GW-1:0] frame_gap = '0;
  logic [GW-1:0] brk_len = '0;
  logic          brk_tvalid = 1'b0;
  logic          brk_tready;
  logic          pd_tvalid = 1'b0;
  logic          pd_tready;
  logic          tx_tvalid = 1'b0;
  logic          tx_tready;
  logic [DW-1:0] tx_tdata = '0;
  logic          tx_tlast = 1'b0;
  logic          tx;
  logic          txEn;

  int total = 0;
  int pass  = 0;

  gj_axis_uart_tx_gen2 #(
    .DATA_W(DW),
    .GAP_W(GW),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .cfg_bits(cfg_bits),
    .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2),
    .cfg_gap_en(cfg_gap_en),
    .byte_gap(byte_gap),
    .frame_gap(frame_gap),
    .brk_len(brk_len),
    .brk_tvalid(brk_tvalid),
    .brk_tready(brk_tready),
    .powerDown_tvalid(pd_tvalid),
    .powerDown_tready(pd_tready),
    .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready),
    .tx_tdata(tx_tdata),
    .tx_tlast(tx_tlast),
    .tx(tx),
    .txEn(txEn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    en_cnt <= en_cnt + 2'd1;
    clk_en <= (en_cnt == 2'd3);
  end

  typedef struct packed {
    logic tx;
    logic en;
    logic pd;
  } samp_t;

  samp_t q[$];

  always @(negedge clk)
    if (clk_en) q.push_back(samp_t'{tx, txEn, pd_tready});

  typedef struct {
    logic [3:0]  bits;
    logic [2:0]  par;
    logic        stop2;
    logic        gap_en;
    logic        mid;
    logic [8:0]  data;
    logic        last;
    int          len;
    logic [63:0] pat;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    total++;
    $display("FAIL %s: got timeout want handshake", nm);
  endtask

  task automatic grab(input int n, output logic [63:0] tv,
                      output logic [63:0] ev, output logic [63:0] pv);
    int s;
    s = -1;
    tv = '0;
    ev = '0;
    pv = '0;
    for (int i = 0; i < q.size(); i++)
      if (q[i].tx == 1'b0) begin
        s = i;
        break;
      end
    if (s < 0) begin
      tv = 'x;
      ev = 'x;
      pv = 'x;
    end else begin
      for (int i = 0; i < n; i++)
        if (s + i < q.size()) begin
          tv[i] = q[s+i].tx;
          ev[i] = q[s+i].en;
          pv[i] = q[s+i].pd;
        end else begin
          tv[i] = 1'bx;
          ev[i] = 1'bx;
          pv[i] = 1'bx;
        end
    end
  endtask

  task automatic send(input logic [8:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    tx_tvalid = 1'b1;
    tx_tdata  = d;
    tx_tlast  = l;
    while (tx_tready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout("send");
    else @(negedge clk);
    tx_tvalid = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] b, input logic [2:0] p,
                         input logic s2, input logic ge);
    cfg_bits   = b;
    cfg_parity = p;
    cfg_stop2  = s2;
    cfg_gap_en = ge;
  endtask

  logic [63:0] tv, ev, pv;
  logic [63:0] exp_en;
  int          n, k, bad, dec, p;
  logic        b_ok, t_ok, acc, saw_low;
  int          first_drop;
  logic [7:0]  d8;

  initial begin
    vt[0] = '{4'd8,  3'd0, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b1, 10, 64'h34A};
    vt[1] = '{4'd7,  3'd1, 1'b1, 1'b0, 1'b0, 9'h041, 1'b1, 11, 64'h682};
    vt[2] = '{4'd7,  3'd2, 1'b1, 1'b0, 1'b0, 9'h041, 1'b1, 11, 64'h782};
    vt[3] = '{4'd9,  3'd3, 1'b0, 1'b0, 1'b0, 9'h1FF, 1'b1, 12, 64'hFFE};
    vt[4] = '{4'd3,  3'd0, 1'b0, 1'b0, 1'b0, 9'h0FF, 1'b1, 7,  64'h07E};
    vt[5] = '{4'd15, 3'd4, 1'b0, 1'b0, 1'b0, 9'h0AA, 1'b1, 12, 64'h954};
    vt[6] = '{4'd5,  3'd6, 1'b1, 1'b0, 1'b0, 9'h013, 1'b0, 8,  64'h0E6};
    vt[7] = '{4'd8,  3'd1, 1'b0, 1'b1, 1'b0, 9'h007, 1'b1, 11, 64'h60E};

    repeat (6) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_txen", txEn, 1'b0);
    chk("rst_tready", tx_tready, 1'b0);
    chk("rst_brk_tready", brk_tready, 1'b0);
    chk("rst_pd_tready", pd_tready, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_pd_tready", pd_tready, 1'b1);
    chk("idle_tx", tx, 1'b1);

    for (int i = 0; i < 8; i++) begin
      set_cfg(vt[i].bits, vt[i].par, vt[i].stop2, vt[i].gap_en);
      byte_gap  = '0;
      frame_gap = '0;
      q.delete();
      send(vt[i].data, vt[i].last);
      if (vt[i].mid) begin
        n = 0;
        while (tx !== 1'b0 && n < 400) begin
          @(negedge clk);
          n++;
        end
        set_cfg(4'd5, 3'd2, 1'b1, 1'b1);
      end
      repeat ((vt[i].len + 6) * 4) @(negedge clk);
      grab(vt[i].len + 1, tv, ev, pv);
      exp_en = (64'd1 << vt[i].len) - 64'd1;
      if (!vt[i].last) exp_en = exp_en | (64'd1 << vt[i].len);
      chk($sformatf("vec%0d_tx", i), tv, vt[i].pat | (64'd1 << vt[i].len));
      chk($sformatf("vec%0d_txen", i), ev, exp_en);
    end

    set_cfg(4'd8, 3'd0, 1'b0, 1'b1);
    byte_gap  = 16'd3;
    frame_gap = 16'd5;
    q.delete();
    send(9'h000, 1'b0);
    send(9'h0FF, 1'b1);
    send(9'h000, 1'b1);
    repeat (80) @(negedge clk);
    grab(29, tv, ev, pv);
    chk("gap_tx", tv, 64'h0FFFDE00);
    chk("gap_txen", ev, 64'h107FFFFF);
    cfg_gap_en = 1'b0;
    repeat (60) @(negedge clk);

    brk_len = 16'd12;
    q.delete();
    @(negedge clk);
    brk_tvalid = 1'b1;
    tx_tvalid  = 1'b1;
    tx_tdata   = 9'h055;
    tx_tlast   = 1'b1;
    n = 0;
    while ((brk_tvalid || tx_tvalid) && n < 600) begin
      b_ok = brk_tready;
      t_ok = tx_tready;
      @(negedge clk);
      n++;
      if (b_ok) brk_tvalid = 1'b0;
      if (t_ok) tx_tvalid = 1'b0;
    end
    if (n >= 600) timeout("brk_handshake");
    brk_tvalid = 1'b0;
    tx_tvalid  = 1'b0;
    repeat (30 * 4) @(negedge clk);
    grab(25, tv, ev, pv);
    chk("brk_tx", tv, 64'h01AAB000);
    chk("brk_txen", ev, 64'h00FFFFFF);
    chk("brk_pd", pv, 64'h01000000);

    brk_len = 16'd0;
    q.delete();
    @(negedge clk);
    brk_tvalid = 1'b1;
    n = 0;
    while (brk_tready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("brk0_handshake");
    @(negedge clk);
    brk_tvalid = 1'b0;
    repeat (8 * 4) @(negedge clk);
    grab(4, tv, ev, pv);
    chk("brk0_tx", tv, 64'hE);
    chk("brk0_txen", ev, 64'h7);

    set_cfg(4'd8, 3'd0, 1'b0, 1'b0);
    q.delete();
    @(negedge clk);
    k = 0;
    n = 0;
    saw_low = 1'b0;
    first_drop = -1;
    tx_tvalid = 1'b1;
    tx_tdata  = 9'd0;
    tx_tlast  = 1'b0;
    while (k < 20 && n < 3000) begin
      acc = tx_tready;
      if (!acc && !saw_low && k > 0) begin
        saw_low = 1'b1;
        first_drop = k;
      end
      @(negedge clk);
      n++;
      if (acc) begin
        k++;
        tx_tdata = 9'(k);
      end
    end
    tx_tvalid = 1'b0;
    if (n >= 3000) timeout("stream_push");
`ifdef GJ_UART_TX_FIFO_EN
    chk("fifo_tready_drop", saw_low, 1'b1);
    chk("fifo_drop_at_full", first_drop >= 16, 1'b1);
`endif
    repeat (1000) @(negedge clk);
    p = 0;
    dec = 0;
    bad = 0;
    while (p < q.size() && dec < 20) begin
      if (q[p].tx == 1'b0) begin
        if (p + 9 >= q.size()) break;
        for (int b = 0; b < 8; b++) d8[b] = q[p+1+b].tx;
        if (d8 != 8'(dec) || q[p+9].tx != 1'b1) bad++;
        dec++;
        p += 10;
      end else begin
        p++;
      end
    end
    chk("stream_count", dec, 20);
    chk("stream_errs", bad, 0);

    send(9'h000, 1'b1);
`ifdef GJ_UART_TX_FIFO_EN
    send(9'h000, 1'b1);
    send(9'h000, 1'b1);
    send(9'h000, 1'b1);
`endif
    n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout("midrst_start");
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_txen", txEn, 1'b0);
    chk("midrst_tready", tx_tready, 1'b0);
    chk("midrst_brk_tready", brk_tready, 1'b0);
    chk("midrst_pd", pd_tready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("postrst_pd", pd_tready, 1'b1);
    q.delete();
    repeat (200) @(negedge clk);
    bad = 0;
    foreach (q[i]) if (q[i].tx !== 1'b1) bad++;
    chk("postrst_line_idle", bad, 0);
    chk("postrst_txen", txEn, 1'b0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
